fifo_vc_bank: RTL and testbench

- Parametrised successor of the single main FIFO: a bank of NUM_CH independent FIFOs sharing one push port, with one pop per channel.
- Each channel has full/empty/almost flags, a pause output with hysteresis, a registered read port and overflow/underflow error flags.
- Sits between the ingress router and the per-VC demux/arbiter; the pause vector feeds upstream flow control.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_vc_chan.sv | 101 ++++++++++
 rtl/fifo_vc_bank.sv | 68 ++++++
 tb/tb_fifo_vc_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the per-VC FIFO bank.
// Flag indices address the packed status vector each channel exports.
package fifo_pkg;

  localparam int EMPTY     = 0;
  localparam int FULL      = 1;
  localparam int AF        = 2;
  localparam int AE        = 3;
  localparam int PAUSE     = 4;
  localparam int NUM_FLAGS = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Channel select is at least one bit wide, even for a single channel.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int count_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_vc_chan.sv
// One virtual-channel FIFO: storage, pointers, occupancy, flags, pause hysteresis, errors.
// FIFO_VC_ERR_STICKY_EN makes err_ovf/err_udf sticky until err_clr.
module fifo_vc_chan
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic [ADDR_SIZE:0]   af_thr,
  input  logic [ADDR_SIZE:0]   ae_thr,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [NUM_FLAGS-1:0] flags,
  output logic                 err_ovf,
  output logic                 err_udf,
  output logic [ADDR_SIZE:0]   count
);

  localparam int CW = count_width(ADDR_SIZE);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic                 pause_q;
  logic                 is_empty, is_full, pop_acc, push_acc, ovf_ev, udf_ev;
  logic                 next_pause;
  logic [CW-1:0]        next_count;

  // Handshake: push/pop are requests with no stall; pop is accepted when not empty,
  // push when not full or when a pop frees a slot the same edge. Rejects raise errors.
  always_comb begin
    is_empty   = (count == '0);
    is_full    = (count == FULL_CNT);
    pop_acc    = pop && !is_empty;
    push_acc   = push && (!is_full || pop_acc);
    ovf_ev     = push && !push_acc;
    udf_ev     = pop && is_empty;
    next_count = count;
    if (push_acc && !pop_acc)      next_count = count + 1'b1;
    else if (pop_acc && !push_acc) next_count = count - 1'b1;
    // Set wins over clear when the thresholds overlap.
    next_pause = pause_q;
    if (next_count >= af_thr)      next_pause = 1'b1;
    else if (next_count <= ae_thr) next_pause = 1'b0;
  end

  always_comb begin
    flags        = '0;
    flags[EMPTY] = is_empty;
    flags[FULL]  = is_full;
    flags[AF]    = (count >= af_thr);
    flags[AE]    = (count <= ae_thr) && !is_empty;
    flags[PAUSE] = pause_q;
  end

  always_ff @(posedge clk) begin
    if (!reset && push_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      pause_q    <= 1'b0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      data_valid <= pop_acc;
      count      <= next_count;
      pause_q    <= next_pause;
`ifdef FIFO_VC_ERR_STICKY_EN
      err_ovf <= ovf_ev || (err_ovf && !err_clr);
      err_udf <= udf_ev || (err_udf && !err_clr);
`else
      err_ovf <= ovf_ev;
      err_udf <= udf_ev;
`endif
    end
  end

`ifndef FIFO_VC_ERR_STICKY_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: rtl/fifo_vc_bank.sv
// Bank of NUM_CH independent FIFOs sharing one push port, one pop per channel.
// FIFO_VC_ERR_STICKY_EN selects sticky error flags cleared by err_clr.
module fifo_vc_bank
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2,
  parameter int NUM_CH    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [ch_width(NUM_CH)-1:0]       push_ch,
  input  logic [DATA_SIZE-1:0]              data_in,
  input  logic [NUM_CH-1:0]                 pop,
  input  logic [ADDR_SIZE:0]                af_thr,
  input  logic [ADDR_SIZE:0]                ae_thr,
  input  logic                              err_clr,
  output logic [NUM_CH*DATA_SIZE-1:0]       data_out,
  output logic [NUM_CH-1:0]                 data_valid,
  output logic [NUM_CH-1:0]                 fifo_empty,
  output logic [NUM_CH-1:0]                 fifo_full,
  output logic [NUM_CH-1:0]                 almost_full,
  output logic [NUM_CH-1:0]                 almost_empty,
  output logic [NUM_CH-1:0]                 pause,
  output logic [NUM_CH-1:0]                 err_ovf,
  output logic [NUM_CH-1:0]                 err_udf,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0]   data_count
);

  localparam int CH_W = ch_width(NUM_CH);
  localparam int CW   = count_width(ADDR_SIZE);

  logic [NUM_CH-1:0]    push_sel;
  logic [NUM_FLAGS-1:0] flg [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range push_ch matches no channel, so the push is silently dropped.
    assign push_sel[i] = push && (push_ch == CH_W'(i));

    fifo_vc_chan #(
      .DATA_SIZE(DATA_SIZE),
      .ADDR_SIZE(ADDR_SIZE)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .push      (push_sel[i]),
      .data_in   (data_in),
      .pop       (pop[i]),
      .af_thr    (af_thr),
      .ae_thr    (ae_thr),
      .err_clr   (err_clr),
      .data_out  (data_out[i*DATA_SIZE +: DATA_SIZE]),
      .data_valid(data_valid[i]),
      .flags     (flg[i]),
      .err_ovf   (err_ovf[i]),
      .err_udf   (err_udf[i]),
      .count     (data_count[i*CW +: CW])
    );

    assign fifo_empty[i]   = flg[i][EMPTY];
    assign fifo_full[i]    = flg[i][FULL];
    assign almost_full[i]  = flg[i][AF];
    assign almost_empty[i] = flg[i][AE];
    assign pause[i]        = flg[i][PAUSE];
  end

endmodule

// File: tb/tb_fifo_vc_bank.sv
// Bench for fifo_vc_bank: directed vectors, a per-channel reference model,
// and a monitor that checks returned words against an expected queue.
module tb_fifo_vc_bank;

  localparam int DS = 6;
  localparam int AS = 2;
  localparam int NC = 4;
  localparam int CW = AS + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic [1:0]       push_ch = '0;
  logic [DS-1:0]    data_in = '0;
  logic [NC-1:0]    pop = '0;
  logic [AS:0]      af_thr = 3'd3;
  logic [AS:0]      ae_thr = 3'd1;
  logic             err_clr = 1'b0;
  logic [NC*DS-1:0] data_out;
  logic [NC-1:0]    data_valid, fifo_empty, fifo_full, almost_full, almost_empty;
  logic [NC-1:0]    pause, err_ovf, err_udf;
  logic [NC*CW-1:0] data_count;

  fifo_vc_bank #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_CH(NC)) dut (
    .clk(clk), .reset(reset), .push(push), .push_ch(push_ch), .data_in(data_in),
    .pop(pop), .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .pause(pause), .err_ovf(err_ovf), .err_udf(err_udf), .data_count(data_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Scoreboard entries are {channel, word}; the monitor scans channels in ascending order.
  logic [7:0] exp_q[$];

  logic [DS-1:0] m_mem [NC][4];
  int            m_wr [NC];
  int            m_rd [NC];
  int            m_cnt [NC];
  logic [NC-1:0] m_pause, m_ovf, m_udf;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      m_wr[i] = 0; m_rd[i] = 0; m_cnt[i] = 0;
    end
    m_pause = '0; m_ovf = '0; m_udf = '0;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    logic [NC-1:0] e_empty, e_full, e_af, e_ae;
    for (int i = 0; i < NC; i++) begin
      cmp($sformatf("%s_cnt%0d", tag, i), 32'(data_count[i*CW +: CW]), m_cnt[i]);
      e_empty[i] = (m_cnt[i] == 0);
      e_full[i]  = (m_cnt[i] == 4);
      e_af[i]    = (m_cnt[i] >= int'(af_thr));
      e_ae[i]    = (m_cnt[i] <= int'(ae_thr)) && (m_cnt[i] != 0);
    end
    cmp({tag, "_empty"}, 32'(fifo_empty), 32'(e_empty));
    cmp({tag, "_full"}, 32'(fifo_full), 32'(e_full));
    cmp({tag, "_af"}, 32'(almost_full), 32'(e_af));
    cmp({tag, "_ae"}, 32'(almost_empty), 32'(e_ae));
    cmp({tag, "_pause"}, 32'(pause), 32'(m_pause));
    cmp({tag, "_ovf"}, 32'(err_ovf), 32'(m_ovf));
    cmp({tag, "_udf"}, 32'(err_udf), 32'(m_udf));
  endtask

  // driver: one clock of stimulus, model update, then post-edge state check
  task automatic cyc(input logic do_push, input logic [1:0] ch, input logic [DS-1:0] d,
                     input logic [NC-1:0] p, input logic clr, input string tag);
    logic [NC-1:0] pa, ovf_ev, udf_ev;
    logic          acc;
    int            nc;
    push = do_push; push_ch = ch; data_in = d; pop = p; err_clr = clr;
    for (int i = 0; i < NC; i++) begin
      pa[i] = p[i] && (m_cnt[i] != 0);
      udf_ev[i] = p[i] && (m_cnt[i] == 0);
      if (pa[i]) exp_q.push_back({2'(i), m_mem[i][m_rd[i]]});
    end
    acc = do_push && ((m_cnt[ch] != 4) || pa[ch]);
    ovf_ev = '0;
    ovf_ev[ch] = do_push && !acc;
    for (int i = 0; i < NC; i++) begin
      nc = m_cnt[i];
      if (acc && (i == int'(ch))) begin
        m_mem[i][m_wr[i]] = d;
        m_wr[i] = (m_wr[i] + 1) % 4;
        if (!pa[i]) nc++;
      end else if (pa[i]) nc--;
      if (pa[i]) m_rd[i] = (m_rd[i] + 1) % 4;
      m_cnt[i] = nc;
      if (nc >= int'(af_thr)) m_pause[i] = 1'b1;
      else if (nc <= int'(ae_thr)) m_pause[i] = 1'b0;
    end
`ifdef FIFO_VC_ERR_STICKY_EN
    m_ovf = ovf_ev | (m_ovf & ~{NC{clr}});
    m_udf = udf_ev | (m_udf & ~{NC{clr}});
`else
    m_ovf = ovf_ev;
    m_udf = udf_ev;
`endif
    @(posedge clk); #1;
    push = 1'b0; pop = '0; err_clr = 1'b0;
    check_state(tag);
  endtask

  // Reset is asserted while requests are active to show it takes priority.
  task automatic do_reset(input string tag);
    reset = 1'b1; push = 1'b1; push_ch = 2'd1; data_in = 6'h3f; pop = '1;
    @(posedge clk); #1;
    reset = 1'b0; push = 1'b0; pop = '0;
    model_clear();
    check_state(tag);
    cmp({tag, "_dout"}, 32'(data_out), 32'h0);
    cmp({tag, "_dvalid"}, 32'(data_valid), 32'h0);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        if (data_valid[i]) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_valid ch%0d actual=%0h required=none", i, data_out[i*DS +: DS]);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            cmp($sformatf("rdata_ch%0d", i), {2'(i), data_out[i*DS +: DS]}, 32'(e));
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");
    cmp("rst0_empty_all", 32'(fifo_empty), 32'hf);

    // ch2 fill, overflow, push+pop while full
    cyc(1'b1, 2'd2, 6'h11, 4'b0000, 1'b0, "p1");
    cmp("p1_cnt2", 32'(data_count[2*CW +: CW]), 32'd1);
    cyc(1'b1, 2'd2, 6'h12, 4'b0000, 1'b0, "p2");
    cmp("p2_pause2", 32'(pause[2]), 32'd0);
    cyc(1'b1, 2'd2, 6'h13, 4'b0000, 1'b0, "p3");
    cmp("p3_pause2", 32'(pause[2]), 32'd1);
    cyc(1'b1, 2'd2, 6'h14, 4'b0000, 1'b0, "p4");
    cmp("p4_full2", 32'(fifo_full[2]), 32'd1);
    cyc(1'b1, 2'd2, 6'h15, 4'b0000, 1'b0, "ovf");
    cmp("ovf_pulse2", 32'(err_ovf[2]), 32'd1);
    cmp("ovf_cnt2", 32'(data_count[2*CW +: CW]), 32'd4);
    cyc(1'b0, 2'd0, 6'h00, 4'b0000, 1'b0, "idle1");
`ifndef FIFO_VC_ERR_STICKY_EN
    cmp("ovf_drop2", 32'(err_ovf[2]), 32'd0);
`else
    cmp("ovf_hold2", 32'(err_ovf[2]), 32'd1);
    cyc(1'b0, 2'd0, 6'h00, 4'b0000, 1'b1, "clr");
    cmp("ovf_cleared2", 32'(err_ovf[2]), 32'd0);
`endif
    cyc(1'b1, 2'd2, 6'h16, 4'b0100, 1'b0, "pp_full");
    cmp("pp_full_cnt2", 32'(data_count[2*CW +: CW]), 32'd4);
    cyc(1'b0, 2'd0, 6'h00, 4'b0100, 1'b0, "pop1");
    cyc(1'b0, 2'd0, 6'h00, 4'b0100, 1'b0, "pop2");
    cmp("pop2_pause_hold", 32'(pause[2]), 32'd1);
    cyc(1'b0, 2'd0, 6'h00, 4'b0100, 1'b0, "pop3");
    cmp("pop3_pause_clr", 32'(pause[2]), 32'd0);
    cyc(1'b0, 2'd0, 6'h00, 4'b0100, 1'b0, "pop4");

    // ch0 underflow, then push+pop on empty
    cyc(1'b0, 2'd0, 6'h00, 4'b0001, 1'b0, "udf");
    cmp("udf_pulse0", 32'(err_udf[0]), 32'd1);
    cyc(1'b1, 2'd0, 6'h2a, 4'b0001, 1'b0, "pp_empty");
    cmp("pp_empty_cnt0", 32'(data_count[0 +: CW]), 32'd1);
    cmp("pp_empty_udf0", 32'(err_udf[0]), 32'd1);
    cyc(1'b0, 2'd0, 6'h00, 4'b0001, 1'b0, "drain0");

    // interleaved ch1/ch3 traffic, both popped every cycle; pointers wrap
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) cyc(1'b1, 2'd1, 6'(6'h20 + k), 4'b1010, 1'b0, "il");
      else            cyc(1'b1, 2'd3, 6'(6'h30 + k), 4'b1010, 1'b0, "il");
    end
    cyc(1'b0, 2'd0, 6'h00, 4'b1010, 1'b0, "il_drain");

    // reset with ch1 holding 3 words
    cyc(1'b1, 2'd1, 6'h01, 4'b0000, 1'b0, "f1");
    cyc(1'b1, 2'd1, 6'h02, 4'b0000, 1'b0, "f2");
    cyc(1'b1, 2'd1, 6'h03, 4'b0000, 1'b0, "f3");
    cmp("f3_pause1", 32'(pause[1]), 32'd1);
    do_reset("rst1");
    cmp("rst1_empty1", 32'(fifo_empty[1]), 32'd1);
    cyc(1'b0, 2'd0, 6'h00, 4'b0000, 1'b0, "tail");
    cyc(1'b0, 2'd0, 6'h00, 4'b0000, 1'b0, "tail");

    cmp("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
